alu_share_ctrl: RTL
===================

Name: alu_share_ctrl

Overview:
- Shares the single combinational 64-bit ALU (num1, num2, operation, result, overflow_flag) between two requesters, e.g. execute stage and address-calc helper.
- Round-robin arbitration with a valid/ready request handshake.
- One registered response slot tagged with the requester id.
- Owns the Y86 condition-code register (ZF, SF, OF) and updates it only for requests flagged set_cc.

Parameters:
- WIDTH, 64, operand/result width; must match the ALU instance.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  WIDTH  operand 1, signed.
- req0_b  in  WIDTH  operand 2, signed.
- req0_op  in  2  00 add, 01 sub (a-b), 10 and, 11 xor.
- req0_setcc  in  1  update CC from this operation.
- req1_valid, req1_ready, req1_a, req1_b, req1_op, req1_setcc  same as above, for requester 1.
- rsp_valid  out  1  response slot full.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  WIDTH  registered ALU result.
- rsp_overflow  out  1  registered overflow (forced 0 for and/xor).
- cc_zf, cc_sf, cc_of  out  1 each  condition-code register.
- alu_num1, alu_num2  out  WIDTH  drive ALU num1/num2.
- alu_operation  out  2  drives ALU operation.
- alu_result  in  WIDTH  from ALU result.
- alu_overflow_flag  in  1  from ALU overflow_flag.

Behaviour:
- Reset (async, immediate): rsp_valid=0, rsp_id=0, rsp_result=0, rsp_overflow=0, cc_zf=1, cc_sf=0, cc_of=0, last_grant=1 (requester 0 wins the first contention).
  - req*_ready=0 while rst is high.
  - Reset mid-operation discards any held response; no CC update.
- Slot free: slot_free = !rsp_valid || rsp_ready.
- Grant (combinational):
  - When slot_free, grant a valid requester. If both are valid, grant the one not equal to last_grant.
  - reqN_ready = grant_N. Ready may depend on valid; requesters must not gate valid on ready.
- ALU drive:
  - alu_num1/alu_num2/alu_operation are muxed from the granted requester.
  - With no grant, they are held at requester last_grant's inputs. Value is don't-care, but must not be X-propagating.
- Accept edge (grant active at rising clk):
  - rsp_result <= alu_result.
  - rsp_overflow <= alu_overflow_flag & ~op[1].
  - rsp_id <= granted id, rsp_valid <= 1, last_grant <= granted id.
  - Latency: one cycle from accept to rsp_valid.
- Response consumption:
  - If rsp_valid && rsp_ready with no new grant, then rsp_valid <= 0.
  - Simultaneous consume and accept: the slot is overwritten with the new result and rsp_valid stays 1, giving full throughput of one op per cycle.
- Stall: rsp_valid && !rsp_ready → both readies 0. rsp_* held stable and last_grant unchanged.
- CC update, only on an accept edge with the granted setcc=1:
  - cc_zf <= (alu_result==0).
  - cc_sf <= alu_result[WIDTH-1].
  - cc_of <= alu_overflow_flag & ~op[1].
  - setcc=0 leaves CC unchanged.
  - CC updates are independent of rsp_ready, since the CC commits at accept.
- Arithmetic: two's complement, WIDTH bits, wrap-around. Overflow is the ALU's signed overflow; the block does not recompute it.
- States:
  - EMPTY (rsp_valid=0) → FULL on accept.
  - FULL → EMPTY on consume without accept.
  - FULL → FULL on stall or on consume+accept.

Decomposition:
- Shared header alu_defs.vh: ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_XOR=2'b11; CC reset values.
- One sub-module rr_arbiter2: inputs clk, rst, req[1:0], en; outputs grant[1:0]. It holds last_grant internally.
- ALU stays external, instantiated alongside this block.

Test Plan:
- Reset, then req0 only: sub, a=9223372036854775807, b=-9223372036854775807, setcc=1 → next cycle rsp_valid=1, rsp_id=0, rsp_result=-2, rsp_overflow=1; cc_zf=0, cc_sf=1, cc_of=1.
- Both valid every cycle, rsp_ready=1, req0 add 5+3, req1 sub 5-5 → grants alternate 0,1,0,1; responses 8 (id0) and 0 (id1) alternate.
  - Only req1 has setcc=1 → after the first id1 accept, cc_zf=1, cc_sf=0, cc_of=0.
- Back-pressure: accept req0 and 1 with -5, b=107, then hold rsp_ready=0 for 3 cycles with req1 valid → req1_ready=0 throughout; rsp_result=-112 held.
  - Raising rsp_ready grants req1 the same cycle.
- Logical ops: and 0xFFFF0000FFFF0000 & 0x0F0F0F0F0F0F0F0F, setcc=1 → result 0x0F0F00000F0F0000; cc_of=0 and rsp_overflow=0 even if the ALU flag is 1.
- Assert rst in the FULL state with setcc pending → rsp_valid=0 immediately (asynchronous); CC=ZF1/SF0/OF0.
  - After release with both valid, requester 0 is granted first.
- Random: 20 accepts of 64-bit random operands with random op → scoreboard matches a reference model of result, overflow and CC; no lost or duplicated response ids.

Source files
------------

// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the shared-ALU controller: ALU opcodes, condition-code
// reset values, the response-slot state type and small opcode helpers.
package alu_share_ctrl_pkg;

  localparam int WIDTH_DEFAULT = 64;

  // ALU operation encodings; these must match the external ALU's decoder
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  // Condition codes come out of reset as "last result was zero"
  localparam logic CC_ZF_RST = 1'b1;
  localparam logic CC_SF_RST = 1'b0;
  localparam logic CC_OF_RST = 1'b0;

  // last_grant resets to requester 1 so requester 0 wins the first contention
  localparam logic LAST_GRANT_RST = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RST = '{zf: CC_ZF_RST, sf: CC_SF_RST, of: CC_OF_RST};

  // Logical ops (and/xor) have bit 1 of the opcode set; they never overflow
  function automatic logic isLogicOp(input logic [1:0] op);
    return op[1];
  endfunction

  // Overflow as committed by this block: the ALU flag, suppressed for logical ops
  function automatic logic maskOverflow(input logic flag, input logic [1:0] op);
    return flag & ~isLogicOp(op);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_arbiter.sv
// Two-way round-robin arbiter. Grants are combinational and only issued while
// en is high; the last granted id is remembered so that under contention the
// other requester wins next.
module rr_arbiter2
  import alu_share_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant,
  output logic       last_grant
);

  logic       r_lastGrant;
  logic [1:0] w_grant;

  // Pick a requester: a lone request wins outright, contention goes to the id
  // that did not win last time
  always_comb begin
    w_grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_lastGrant ? 2'b01 : 2'b10;
        default: w_grant = 2'b00;
      endcase
    end
  end

  // Remember the winner of every issued grant; idle or stalled cycles keep it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lastGrant <= LAST_GRANT_RST;
    end else if (w_grant[1]) begin
      r_lastGrant <= 1'b1;
    end else if (w_grant[0]) begin
      r_lastGrant <= 1'b0;
    end
  end

  assign grant      = w_grant;
  assign last_grant = r_lastGrant;

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between two requesters using a
// round-robin arbiter, a single registered response slot tagged with the
// requester id, and owns the Y86 condition-code register (ZF/SF/OF).
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req0_setcc,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  input  logic             req1_setcc,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_overflow,

  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of,

  output logic [WIDTH-1:0] alu_num1,
  output logic [WIDTH-1:0] alu_num2,
  output logic [1:0]       alu_operation,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow_flag
);

  slot_state_t      r_state;
  logic             r_rspId;
  logic [WIDTH-1:0] r_rspResult;
  logic             r_rspOverflow;
  cc_t              r_cc;

  logic             w_slotFree;
  logic             w_arbEn;
  logic [1:0]       w_grant;
  logic             w_lastGrant;
  logic             w_accept;
  logic             w_sel;
  logic             w_setcc;
  logic             w_ovfMasked;

  // The slot can take a new result when empty or when its current content is
  // being consumed this very cycle; nothing is granted while reset is held
  assign w_slotFree = (r_state == SLOT_EMPTY) || rsp_ready;
  assign w_arbEn    = w_slotFree && !rst;

  rr_arbiter2 u_arbiter (
    .clk        (clk),
    .rst        (rst),
    .req        ({req1_valid, req0_valid}),
    .en         (w_arbEn),
    .grant      (w_grant),
    .last_grant (w_lastGrant)
  );

  assign w_accept   = |w_grant;
  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];

  // With no grant the ALU keeps looking at the last winner's inputs so its
  // operands stay known-valued rather than floating
  assign w_sel = w_grant[1] | (~w_grant[0] & w_lastGrant);

  assign alu_num1      = w_sel ? req1_a  : req0_a;
  assign alu_num2      = w_sel ? req1_b  : req0_b;
  assign alu_operation = w_sel ? req1_op : req0_op;
  assign w_setcc       = w_sel ? req1_setcc : req0_setcc;

  assign w_ovfMasked = maskOverflow(alu_overflow_flag, alu_operation);

  // Response slot state machine: an accept always (re)loads the slot, a
  // consume without an accept empties it, a stall leaves everything untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= SLOT_EMPTY;
      r_rspId       <= 1'b0;
      r_rspResult   <= '0;
      r_rspOverflow <= 1'b0;
    end else begin
      case (r_state)
        SLOT_EMPTY: begin
          if (w_accept) begin
            r_state       <= SLOT_FULL;
            r_rspId       <= w_grant[1];
            r_rspResult   <= alu_result;
            r_rspOverflow <= w_ovfMasked;
          end
        end
        SLOT_FULL: begin
          if (w_accept) begin
            r_state       <= SLOT_FULL;
            r_rspId       <= w_grant[1];
            r_rspResult   <= alu_result;
            r_rspOverflow <= w_ovfMasked;
          end else if (rsp_ready) begin
            r_state <= SLOT_EMPTY;
          end
        end
        default: begin
          r_state <= SLOT_EMPTY;
        end
      endcase
    end
  end

  // Condition codes commit at accept time for setcc requests, independent of
  // when the consumer eventually drains the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cc <= CC_RST;
    end else if (w_accept && w_setcc) begin
      r_cc.zf <= (alu_result == '0);
      r_cc.sf <= alu_result[WIDTH-1];
      r_cc.of <= w_ovfMasked;
    end
  end

  assign rsp_valid    = (r_state == SLOT_FULL);
  assign rsp_id       = r_rspId;
  assign rsp_result   = r_rspResult;
  assign rsp_overflow = r_rspOverflow;

  assign cc_zf = r_cc.zf;
  assign cc_sf = r_cc.sf;
  assign cc_of = r_cc.of;

endmodule
